// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; multi-cycle ops report Busy until results commit.
// Optional macro MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate ops (codes 7-10).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  MDOP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          cmt_q, cmt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;

  logic signed [63:0] sprod;
  logic        [63:0] uprod;

  // Returns {remainder, quotient}; the one overflowing case is pinned explicitly.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    if (b == 32'h0)
      return 64'h0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0)
      return 64'h0;
    return {a % b, a / b};
  endfunction

  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'h0, A} * {32'h0, B};

  always_comb begin
    cnt_d = cnt_q;
    cmt_d = cmt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    if (Flush) begin
      cnt_d = '0;
      cmt_d = 1'b0;
      phi_d = '0;
      plo_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      // Commit on the 1->0 step so new HI/LO appear the cycle Busy drops.
      if (cnt_q == CW'(1) && cmt_q) begin
        hi_d  = phi_q;
        lo_d  = plo_q;
        cmt_d = 1'b0;
      end
    end else if (Start) begin
      case (MDOP)
        4'd1: begin {phi_d, plo_d} = sprod; cmt_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
        4'd2: begin {phi_d, plo_d} = uprod; cmt_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
        4'd3: begin {phi_d, plo_d} = sdiv(A, B); cmt_d = (B != 32'h0); cnt_d = CW'(DIV_CYCLES); end
        4'd4: begin {phi_d, plo_d} = udiv(A, B); cmt_d = (B != 32'h0); cnt_d = CW'(DIV_CYCLES); end
        4'd5: hi_d = A;
        4'd6: lo_d = A;
`ifdef MDU_MADD_EN
        4'd7:  begin {phi_d, plo_d} = {hi_q, lo_q} + sprod; cmt_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
        4'd8:  begin {phi_d, plo_d} = {hi_q, lo_q} + uprod; cmt_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
        4'd9:  begin {phi_d, plo_d} = {hi_q, lo_q} - sprod; cmt_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
        4'd10: begin {phi_d, plo_d} = {hi_q, lo_q} - uprod; cmt_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
`endif
        default: ;
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      cmt_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      cmt_q  <= cmt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
